// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, PC step and the fetch packet
// handed from the fetch stage to decode.
package core_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_STEP = 4;

    // One fetched instruction together with the byte PC it came from.
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_pkt_t;

    // Word-align a byte address by clearing the two low bits.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch packets with flush. The head entry is
// presented combinationally; push and pop may coincide even when full
// because the slot being written is the one being popped this cycle.
module fetch_fifo
    import core_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  fetch_pkt_t       wdata_i,
    output fetch_pkt_t       rdata_o,
    output logic [CNT_W-1:0] count_o
);

    fetch_pkt_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en;

    assign wr_en   = push_i && !flush_i;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next pointer/occupancy: flush empties the queue and rewinds both pointers.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; written at the write pointer on every accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, addresses the ROM, and buffers
// {pc, instr} pairs for decode. Redirects replace the PC and flush the
// buffer; fetch resumes at the target on the following cycle.
module instr_fetch
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [XLEN-1:0]    rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [XLEN-1:0]    out_pc
);

    localparam int unsigned      CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] count;
    logic             push, pop, flush;
    fetch_pkt_t       wr_pkt, head_pkt;

    assign rom_addr = {2'b00, pc_q[XLEN-1:2]};

    // Handshake: a pop alongside a redirect is still consumed by decode,
    // but the flush wins inside the FIFO and no new fetch is pushed.
    always_comb begin
        pop   = out_valid && out_ready;
        flush = redirect_valid;
        push  = !redirect_valid && ((count < FULL) || pop);
    end

    // Next PC: redirect target, else advance on each accepted fetch.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = word_align(redirect_pc);
        end else if (push) begin
            pc_d = pc_q + XLEN'(PC_STEP);
        end
    end

    // Program counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign wr_pkt = '{pc: pc_q, instr: rom_data};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (wr_pkt),
        .rdata_o (head_pkt),
        .count_o (count)
    );

    assign out_valid = (count != '0);
    assign out_instr = head_pkt.instr;
    assign out_pc    = head_pkt.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch. ROM[i] = 0x1000_0000 + i.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_ready = 1'b0;

    logic [31:0] rom_addr, rom_data, out_instr, out_pc;
    logic        out_valid;
    logic [31:0] rom_addr2, rom_data2, out_instr2, out_pc2;
    logic        out_valid2;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [31:0] exp_q [$];
    logic [31:0] e;

    always #5 clk = ~clk;

    assign rom_data  = 32'h1000_0000 + {24'h0, rom_addr[7:0]};
    assign rom_data2 = 32'h1000_0000 + {24'h0, rom_addr2[7:0]};

    instr_fetch u_dut (
        .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr2), .rom_data(rom_data2),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_instr(out_instr2), .out_pc(out_pc2)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        return 32'h1000_0000 + {24'h0, pc[9:2]};
    endfunction

    // Hold reset for two cycles; returns on a falling edge with rst_n just
    // released, so the next rising edge is the first release edge.
    task automatic do_reset(input logic ready);
        @(negedge clk);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        out_ready = ready;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        vectors++;
        if (rom_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rom_addr: got %h want 00000000", rom_addr);
        end
    endtask

    task automatic test_stream;
        do_reset(1'b1);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_pre_edge_valid: got %b want 0", out_valid);
        end
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        repeat (4) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL stream_valid: got %b want 1", out_valid);
            end else begin
                e = exp_q.pop_front();
                if (out_pc !== e || out_instr !== rom_word(e)) begin
                    miscompares++;
                    $display("FAIL stream_data: got pc %h instr %h want pc %h instr %h",
                             out_pc, out_instr, e, rom_word(e));
                end
            end
        end
    endtask

    task automatic test_backpressure;
        do_reset(1'b0);
        repeat (5) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
                miscompares++;
                $display("FAIL bp_hold: got valid %b pc %h want 1 00000000", out_valid, out_pc);
            end
        end
        vectors++;
        if (rom_addr !== 32'h2) begin
            miscompares++;
            $display("FAIL bp_rom_addr: got %h want 00000002", rom_addr);
        end
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
        out_ready = 1'b1;
        repeat (6) begin
            vectors++;
            if (out_valid !== 1'b1 || exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL bp_stream_valid: got %b want 1", out_valid);
            end else begin
                e = exp_q.pop_front();
                if (out_pc !== e || out_instr !== rom_word(e)) begin
                    miscompares++;
                    $display("FAIL bp_stream_data: got pc %h instr %h want pc %h instr %h",
                             out_pc, out_instr, e, rom_word(e));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect_full;
        do_reset(1'b0);
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0043;
        @(negedge clk);
        redirect_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_flush_valid: got %b want 0", out_valid);
        end
        vectors++;
        if (rom_addr !== 32'h10) begin
            miscompares++;
            $display("FAIL redir_rom_addr: got %h want 00000010", rom_addr);
        end
        @(negedge clk);
        exp_q = '{32'h40, 32'h44, 32'h48};
        out_ready = 1'b1;
        repeat (3) begin
            vectors++;
            if (out_valid !== 1'b1 || exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL redir_valid: got %b want 1", out_valid);
            end else begin
                e = exp_q.pop_front();
                if (out_pc !== e || out_instr !== rom_word(e)) begin
                    miscompares++;
                    $display("FAIL redir_data: got pc %h instr %h want pc %h instr %h",
                             out_pc, out_instr, e, rom_word(e));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect_pop;
        do_reset(1'b1);
        @(negedge clk);
        exp_q = '{32'h0};
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0080;
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rp_pop_valid: got %b want 1", out_valid);
        end else begin
            e = exp_q.pop_front();
            if (out_pc !== e || out_instr !== rom_word(e)) begin
                miscompares++;
                $display("FAIL rp_pop_data: got pc %h instr %h want pc %h", out_pc, out_instr, e);
            end
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rp_flush_valid: got %b want 0", out_valid);
        end
        exp_q = '{32'h80, 32'h84, 32'h88};
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rp_valid: got %b want 1", out_valid);
            end else begin
                e = exp_q.pop_front();
                if (out_pc !== e || out_instr !== rom_word(e)) begin
                    miscompares++;
                    $display("FAIL rp_data: got pc %h instr %h want pc %h instr %h",
                             out_pc, out_instr, e, rom_word(e));
                end
            end
        end
    endtask

    task automatic test_async_reset;
        do_reset(1'b1);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL async_valid: got %b want 0", out_valid);
        end
        vectors++;
        if (rom_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL async_rom_addr: got %h want 00000000", rom_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q = '{32'h0, 32'h4, 32'h8};
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL async_restart_valid: got %b want 1", out_valid);
            end else begin
                e = exp_q.pop_front();
                if (out_pc !== e || out_instr !== rom_word(e)) begin
                    miscompares++;
                    $display("FAIL async_restart_data: got pc %h instr %h want pc %h instr %h",
                             out_pc, out_instr, e, rom_word(e));
                end
            end
        end
    endtask

    task automatic test_pc_wrap;
        logic [7:0] exp_addr [$];
        do_reset(1'b1);
        exp_addr = '{8'hFF, 8'h00, 8'h01};
        vectors++;
        if (rom_addr2[7:0] !== 8'hFE) begin
            miscompares++;
            $display("FAIL wrap_rom_addr0: got %h want fe", rom_addr2[7:0]);
        end
        exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (rom_addr2[7:0] !== exp_addr[0]) begin
                miscompares++;
                $display("FAIL wrap_rom_addr: got %h want %h", rom_addr2[7:0], exp_addr[0]);
            end
            void'(exp_addr.pop_front());
            vectors++;
            if (out_valid2 !== 1'b1 || exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL wrap_valid: got %b want 1", out_valid2);
            end else begin
                e = exp_q.pop_front();
                if (out_pc2 !== e || out_instr2 !== rom_word(e)) begin
                    miscompares++;
                    $display("FAIL wrap_data: got pc %h instr %h want pc %h instr %h",
                             out_pc2, out_instr2, e, rom_word(e));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_redirect_pop();
        test_async_reset();
        test_pc_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage: holds the program counter, drives the word address of the 256-word instruction ROM, and captures its combinational read data into a 2-entry buffer. The buffer presents {pc, instr} pairs to the decode stage under a valid/ready handshake. It sits between the ROM and decode, and accepts PC redirects from the execute/branch unit.

## Interface
- `RESET_PC`, 32'h0000_0000: byte address fetched first after reset; bits [1:0] must be zero.
- `DEPTH`, 2: buffer entries; only 2 is supported.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rom_addr`  out  32  word index to ROM, `{2'b00, pc[31:2]}`; the ROM uses bits [7:0].
- `rom_data`  in  32  combinational ROM read data for `rom_addr`, same cycle.
- `redirect_valid`  in  1  branch/jump taken; replace PC and flush.
- `redirect_pc`  in  32  new byte PC; bits [1:0] ignored and forced to 0.
- `out_valid`  out  1  buffer head holds a valid instruction.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_instr`  out  32  instruction at buffer head.
- `out_pc`  out  32  byte PC of `out_instr`.

## Operation
- State: `pc` (32 bits), buffer entries, `count` (0..2), and read/write pointers (1 bit each, wrapping).
- Pop: `out_valid && out_ready`.
- Push: `count < 2 || pop`. On push, write `{pc, rom_data}` and set `pc <= pc + 4`.
- PC arithmetic is modulo 2^32: 0xFFFF_FFFC + 4 = 0x0000_0000. ROM aliasing every 1 KiB of PC is intended.
- No push: `pc` holds; `rom_addr` stays stable.
- Redirect, highest priority:
  - `count <= 0`, pointers reset, no push that cycle.
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - A pop coinciding with redirect still counts as consumed by decode; the rest of the buffer is discarded.
- `count` update (no redirect): +1 push only, −1 pop only, unchanged for push+pop or neither. Push+pop at `count == 2` is legal.
- `out_valid = (count != 0)`; `out_instr`/`out_pc` come from the head entry and are held stable while `out_valid && !out_ready`.
- Outputs with `count == 0` are don't-care.

## Timing
- Reset (`rst_n` low, asynchronous):
  - `pc = RESET_PC`, `count = 0`, pointers = 0.
  - `out_valid = 0` immediately; `rom_addr = RESET_PC >> 2`.
  - A mid-operation assert discards all buffered instructions at once.
- First release edge: push `RESET_PC`. `out_valid = 1` in the cycle after that edge.
- Steady state with `out_ready = 1`: one instruction per cycle, consecutive PCs; fetch-to-output latency is 1 cycle.
- `out_ready = 0`: the buffer fills in 2 cycles. Then `pc` freezes at the third address; no instruction is lost or duplicated.
- Redirect in cycle N: `out_valid = 0` in cycle N+1; the target instruction appears with `out_valid = 1` in cycle N+2.
- Back-to-back redirects: the last one wins, and each one flushes.

## Structure
- Shared package `core_pkg`: `XLEN = 32`, `INSTR_W = 32`, `PC_STEP = 4`, and a packed struct `fetch_pkt_t {pc, instr}` shared with decode.
- Sub-module `fetch_fifo`: 2-entry synchronous FIFO of `fetch_pkt_t` with `push`, `pop`, `flush`, `count`, async active-low reset.
- `instr_fetch` holds only the PC, push/pop/flush logic and ROM addressing.

## Test plan
- Reset release with ROM[i] = 0x1000_0000 + i and `out_ready = 1` → cycles 1..4 emit pc 0x0, 0x4, 0x8, 0xC with instr 0x1000_0000..0x1000_0003.
- Backpressure: hold `out_ready = 0` for 5 cycles after first valid → `out_pc` stays 0x0 and `rom_addr` freezes at 2. On release, the stream is 0x0, 0x4, 0x8… with no gaps or repeats.
- Redirect to 0x0000_0043 while buffer full → next cycle `out_valid = 0`, then `out_pc = 0x40` with instr ROM[16]. Old entries never appear.
- Redirect and pop in the same cycle → the popped instruction counts as consumed, then the stream resumes at the target.
- Async reset mid-stream (`rst_n` low between edges) → `out_valid` drops without a clock edge, and the stream restarts at `RESET_PC`.
- `RESET_PC = 0xFFFF_FFF8` → PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 with `rom_addr` [7:0] = 0xFE, 0xFF, 0x00.
